// File: rtl/debouncer_bank.sv
// debouncer_bank: multi-channel input debouncer.
// Each channel passes its raw input through a two-stage synchroniser, then
// requires the synchronised level to differ from the debounced level for a
// full stability interval before the debounced level follows it. A shared
// prescaler slows the stability timers down so long debounce times do not
// need wide per-channel counters. Rising/falling edge pulses and the
// aggregate "changed" flag are registered alongside the debounced level.

module debouncer_bank #(
   parameter int                      channelCount             = 8,
   parameter int                      timerWidth               = 16,
   parameter int                      timerInitializationValue = 50000,
   parameter int                      tickDivisor              = 1,
   parameter logic [channelCount-1:0] resetValue               = {channelCount{1'b0}}
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [channelCount-1:0] dataIn,
   output logic [channelCount-1:0] dataOut,
   output logic [channelCount-1:0] risingEdge,
   output logic [channelCount-1:0] fallingEdge,
   output logic                    changed
);

   // A divisor of 1 would give a zero-width counter, so keep at least one bit.
   localparam int prescWidth = (tickDivisor > 1) ? $clog2(tickDivisor) : 1;
   localparam logic [prescWidth-1:0] lastCount   = prescWidth'(tickDivisor - 1);
   localparam logic [timerWidth-1:0] reloadValue = timerWidth'(timerInitializationValue);

   logic [channelCount-1:0] sync1;
   logic [channelCount-1:0] sync2;
   logic [prescWidth-1:0]   prescaler;
   logic                    tick;
   logic [timerWidth-1:0]   timer [channelCount];
   logic [channelCount-1:0] commit;

   // The prescaler only advances while enabled; tick marks its last count.
   always_comb begin
      tick = enable && (prescaler == lastCount);
   end

   // A channel commits when its synchronised level still disagrees with the
   // debounced level after the timer has fully drained; this does not wait
   // for a tick, so the timer can never be asked to go below zero.
   always_comb begin
      commit = '0;
      for (int i = 0; i < channelCount; i++) begin
         commit[i] = (sync2[i] != dataOut[i]) && (timer[i] == '0);
      end
   end

   // Two-stage synchroniser; only sync2 is used by the decision logic.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= resetValue;
         sync2 <= resetValue;
      end else begin
         sync1 <= dataIn;
         sync2 <= sync1;
      end
   end

   // Shared prescaler counter: wraps on tick and freezes while disabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         prescaler <= '0;
      end else if (enable) begin
         if (tick) begin
            prescaler <= '0;
         end else begin
            prescaler <= prescaler + prescWidth'(1);
         end
      end
   end

   // Per-channel stability timer and debounced level. Agreement always
   // reloads the timer (even while disabled) so any disagreement must be
   // continuous for its whole interval; a commit reloads it for the next one.
   always_ff @(posedge clock) begin
      if (reset) begin
         dataOut <= resetValue;
         for (int i = 0; i < channelCount; i++) begin
            timer[i] <= reloadValue;
         end
      end else begin
         for (int i = 0; i < channelCount; i++) begin
            if (sync2[i] == dataOut[i]) begin
               timer[i] <= reloadValue;
            end else if (commit[i]) begin
               dataOut[i] <= sync2[i];
               timer[i]   <= reloadValue;
            end else if (tick) begin
               timer[i] <= timer[i] - timerWidth'(1);
            end
         end
      end
   end

   // Edge pulses and the aggregate flag are registered in the same edge that
   // updates dataOut, so they are visible exactly in the following cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         risingEdge  <= '0;
         fallingEdge <= '0;
         changed     <= 1'b0;
      end else begin
         risingEdge  <= commit & sync2;
         fallingEdge <= commit & ~sync2;
         changed     <= |commit;
      end
   end

endmodule

// File: tb/tb_debouncer_bank.sv
// tb_debouncer_bank: drives three debouncer_bank instances (normal timing,
// prescaled timing, zero-length timer) with the same inputs and compares
// every output each cycle against a behavioural model of the debounce rules.

module tb_debouncer_bank;

   localparam int CH = 4;
   localparam int TW = 2;
   localparam logic [CH-1:0] RV = '0;

   // Per-instance timer reload value and prescaler divisor.
   int tVal [3] = '{3, 3, 0};
   int dVal [3] = '{1, 4, 1};

   logic          clock;
   logic          reset;
   logic          enable;
   logic [CH-1:0] dataIn;

   logic [CH-1:0] dOut  [3];
   logic [CH-1:0] rEdge [3];
   logic [CH-1:0] fEdge [3];
   logic          chg   [3];

   int passCount = 0;
   int checkCount = 0;

   // Model state: delayed input history, debounced level, count of ticks seen
   // during the current disagreement run, and enabled-edge count since reset.
   logic [CH-1:0] mHist1 [3];
   logic [CH-1:0] mHist2 [3];
   logic [CH-1:0] mOut   [3];
   logic [CH-1:0] mRise  [3];
   logic [CH-1:0] mFall  [3];
   logic          mChg   [3];
   int            mRun   [3][CH];
   int            mEn    [3];

   debouncer_bank #(
      .channelCount(CH), .timerWidth(TW), .timerInitializationValue(3),
      .tickDivisor(1), .resetValue(RV)
   ) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .dataIn(dataIn),
      .dataOut(dOut[0]), .risingEdge(rEdge[0]), .fallingEdge(fEdge[0]), .changed(chg[0])
   );

   debouncer_bank #(
      .channelCount(CH), .timerWidth(TW), .timerInitializationValue(3),
      .tickDivisor(4), .resetValue(RV)
   ) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .dataIn(dataIn),
      .dataOut(dOut[1]), .risingEdge(rEdge[1]), .fallingEdge(fEdge[1]), .changed(chg[1])
   );

   debouncer_bank #(
      .channelCount(CH), .timerWidth(TW), .timerInitializationValue(0),
      .tickDivisor(1), .resetValue(RV)
   ) dut2 (
      .clock(clock), .reset(reset), .enable(enable), .dataIn(dataIn),
      .dataOut(dOut[2]), .risingEdge(rEdge[2]), .fallingEdge(fEdge[2]), .changed(chg[2])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance the model by one clock edge using the inputs the edge will see.
   task automatic modelStep(input logic r, input logic e, input logic [CH-1:0] d);
      logic          tick;
      logic [CH-1:0] newOut;
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            mHist1[k] = RV;
            mHist2[k] = RV;
            mOut[k]   = RV;
            mRise[k]  = '0;
            mFall[k]  = '0;
            mChg[k]   = 1'b0;
            mEn[k]    = 0;
            for (int i = 0; i < CH; i++) mRun[k][i] = 0;
         end else begin
            tick     = e && ((mEn[k] % dVal[k]) == dVal[k] - 1);
            newOut   = mOut[k];
            mRise[k] = '0;
            mFall[k] = '0;
            for (int i = 0; i < CH; i++) begin
               if (mHist2[k][i] == mOut[k][i]) begin
                  mRun[k][i] = 0;
               end else if (mRun[k][i] >= tVal[k]) begin
                  newOut[i] = mHist2[k][i];
                  if (mHist2[k][i]) mRise[k][i] = 1'b1;
                  else              mFall[k][i] = 1'b1;
                  mRun[k][i] = 0;
               end else if (tick) begin
                  mRun[k][i] = mRun[k][i] + 1;
               end
            end
            mChg[k]   = |(mRise[k] | mFall[k]);
            mOut[k]   = newOut;
            mHist2[k] = mHist1[k];
            mHist1[k] = d;
            if (e) mEn[k] = mEn[k] + 1;
         end
      end
   endtask

   task automatic checkOne(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
   endtask

   task automatic checkOutput();
      for (int k = 0; k < 3; k++) begin
         checkOne($sformatf("dut%0d.dataOut", k), dOut[k], mOut[k]);
         checkOne($sformatf("dut%0d.risingEdge", k), rEdge[k], mRise[k]);
         checkOne($sformatf("dut%0d.fallingEdge", k), fEdge[k], mFall[k]);
         checkOne($sformatf("dut%0d.changed", k), {3'b000, chg[k]}, {3'b000, mChg[k]});
      end
   endtask

   // Drive one cycle of inputs, let one edge pass, then compare.
   task automatic applyStimulus(input logic r, input logic e, input logic [CH-1:0] d);
      reset  = r;
      enable = e;
      dataIn = d;
      modelStep(r, e, d);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   initial begin
      int            edges;
      logic [CH-1:0] rnd;
      logic          rEn;
      logic          rRst;

      reset  = 1'b1;
      enable = 1'b1;
      dataIn = '0;
      $display("[TB] starting");

      // Reset, then quiet inputs: nothing should move.
      repeat (3) applyStimulus(1'b1, 1'b1, 4'b0000);
      repeat (50) applyStimulus(1'b0, 1'b1, 4'b0000);

      // Held rising input on channel 0; measure edges until dataOut follows.
      edges = 0;
      while (edges < 20 && dOut[0][0] !== 1'b1) begin
         applyStimulus(1'b0, 1'b1, 4'b0001);
         edges++;
      end
      checkCount++;
      assert (edges == 6) passCount++;
      else $error("[TB] FAIL latency0: observed %0d edges expected %0d", edges, 6);
      repeat (20) applyStimulus(1'b0, 1'b1, 4'b0001);

      // Channel 1 high for exactly four cycles: just long enough to rise, then fall.
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000);
      repeat (4) applyStimulus(1'b0, 1'b1, 4'b0010);
      repeat (25) applyStimulus(1'b0, 1'b1, 4'b0000);

      // Channel 2 glitches of three and two cycles: too short to register.
      repeat (3) applyStimulus(1'b0, 1'b1, 4'b0100);
      repeat (10) applyStimulus(1'b0, 1'b1, 4'b0000);
      repeat (2) applyStimulus(1'b0, 1'b1, 4'b0100);
      repeat (20) applyStimulus(1'b0, 1'b1, 4'b0000);

      // All channels high while disabled, then enabled.
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000);
      repeat (10) applyStimulus(1'b0, 1'b0, 4'b1111);
      repeat (25) applyStimulus(1'b0, 1'b1, 4'b1111);

      // Reset in the middle of a pending change on channel 3.
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000);
      repeat (3) applyStimulus(1'b0, 1'b1, 4'b1000);
      applyStimulus(1'b1, 1'b1, 4'b1000);
      repeat (25) applyStimulus(1'b0, 1'b1, 4'b1000);

      // Randomised inputs with occasional toggles, enable drops and resets.
      rnd = '0;
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 7) == 0) rnd[i] = ~rnd[i];
         end
         rEn  = ($urandom_range(0, 9) != 0);
         rRst = ($urandom_range(0, 199) == 0);
         applyStimulus(rRst, rEn, rnd);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
